// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : segment encoding table and blanking constants for the scan driver
// Rev 1.0
// ============================================================================
package seg7_pkg;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Entry n is the active-low g..a pattern for hex digit n (entry 0 is rightmost).
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg7_enc(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_prescaler.sv
`default_nettype none
// ============================================================================
// seg7_prescaler : slot timer (pre) and digit index (idx) with slot/frame strobes
// Rev 1.0
// ============================================================================
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int PRE_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PRE_W-1:0] pre,
  output logic [2:0]       idx,
  output logic             slot_end,
  output logic             frame_end
);

  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (slot_end) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign slot_end  = (r_pre == c_PRE_LAST);
  assign frame_end = slot_end && (r_idx == 3'd7);
  assign pre       = r_pre;
  assign idx       = r_idx;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : 8-digit common-anode 7-segment scanner with frame-synchronous
//                    value update, leading-zero suppression and ghost blanking
// Rev 1.0
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESET,
  input  logic [31:0] value,
  input  logic        value_valid,
  input  logic [7:0]  dp_mask,
  input  logic        lz_en,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_done
);

  localparam int               PRE_W   = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] c_BLANK = PRE_W'(BLANK_CYCLES);

  logic [PRE_W-1:0] w_pre;
  logic [2:0]       w_idx;
  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_unused_slot_end;

  seg7_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .PRE_W       (PRE_W)
  ) u_prescaler (
    .clk       (CLK100MHZ),
    .rst       (CPU_RESET),
    .pre       (w_pre),
    .idx       (w_idx),
    .slot_end  (w_slot_end),
    .frame_end (w_frame_end)
  );

  assign w_unused_slot_end = w_slot_end;

  logic [31:0] r_cap_val,  r_disp_val;
  logic [7:0]  r_cap_dp,   r_disp_dp;
  logic        r_cap_lz,   r_disp_lz;

  // disp reads the pre-edge cap, so a strobe on the boundary cycle waits one frame.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_cap_val  <= '0;
      r_cap_dp   <= '0;
      r_cap_lz   <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_lz  <= 1'b0;
    end else begin
      if (value_valid) begin
        r_cap_val <= value;
        r_cap_dp  <= dp_mask;
        r_cap_lz  <= lz_en;
      end
      if (w_frame_end) begin
        r_disp_val <= r_cap_val;
        r_disp_dp  <= r_cap_dp;
        r_disp_lz  <= r_cap_lz;
      end
    end
  end

  // Bit k set when nibbles k..7 of the displayed value are all zero.
  logic [7:0] w_upper_zero;
  for (genvar k = 0; k < 8; k++) begin : g_upper_zero
    assign w_upper_zero[k] = (r_disp_val[31:4*k] == '0);
  end

  logic [3:0] w_nibble;
  logic       w_digit_blank;
  logic       w_lit;

  assign w_nibble      = r_disp_val[{w_idx, 2'b00} +: 4];
  assign w_digit_blank = r_disp_lz && (w_idx != 3'd0) && w_upper_zero[w_idx];
  assign w_lit         = (w_pre >= c_BLANK);

  logic [7:0] r_anode;
  logic [6:0] r_cathode;
  logic       r_dp;
  logic       r_frame_done;

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_anode      <= ANODE_OFF;
      r_cathode    <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (!w_lit) begin
        r_anode   <= ANODE_OFF;
        r_cathode <= SEG_OFF;
        r_dp      <= 1'b1;
      end else begin
        r_anode <= ~(8'd1 << w_idx);
        if (w_digit_blank) begin
          r_cathode <= SEG_OFF;
          r_dp      <= 1'b1;
        end else begin
          r_cathode <= seg7_enc(w_nibble);
          r_dp      <= ~r_disp_dp[w_idx];
        end
      end
    end
  end

  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// tb_seg7_scan_driver : directed and randomized checks of seg7_scan_driver against
// a reference model that derives slot/digit from a plain cycle count since reset.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * RD;

  logic        CLK100MHZ   = 1'b0;
  logic        CPU_RESET   = 1'b1;
  logic [31:0] value       = '0;
  logic        value_valid = 1'b0;
  logic [7:0]  dp_mask     = '0;
  logic        lz_en       = 1'b0;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .CLK100MHZ   (CLK100MHZ),
    .CPU_RESET   (CPU_RESET),
    .value       (value),
    .value_valid (value_valid),
    .dp_mask     (dp_mask),
    .lz_en       (lz_en),
    .anode       (anode),
    .cathode     (cathode),
    .dp          (dp),
    .frame_done  (frame_done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  logic [6:0] ref_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: outputs after an edge follow from the cycle count n before it.
  int unsigned m_n;
  logic [31:0] m_cap_val, m_disp_val;
  logic [7:0]  m_cap_dp,  m_disp_dp;
  logic        m_cap_lz,  m_disp_lz;
  logic [7:0]  e_anode;
  logic [6:0]  e_cathode;
  logic        e_dp, e_fd;

  always @(posedge CLK100MHZ or posedge CPU_RESET) begin
    int p, d;
    logic [3:0] nib;
    if (CPU_RESET) begin
      m_n = 0;
      m_cap_val = '0; m_cap_dp = '0; m_cap_lz = 1'b0;
      m_disp_val = '0; m_disp_dp = '0; m_disp_lz = 1'b0;
      e_anode = 8'hFF; e_cathode = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      p = int'(m_n % RD);
      d = int'((m_n / RD) % 8);
      e_fd = ((m_n % FRAME) == FRAME - 1);
      if (p < BC) begin
        e_anode = 8'hFF; e_cathode = 7'h7F; e_dp = 1'b1;
      end else begin
        e_anode = ~(8'h01 << d);
        nib = m_disp_val[4*d +: 4];
        if (m_disp_lz && d > 0 && (m_disp_val >> (4*d)) == 32'd0) begin
          e_cathode = 7'h7F; e_dp = 1'b1;
        end else begin
          e_cathode = ref_seg[nib]; e_dp = ~m_disp_dp[d];
        end
      end
      if (e_fd) begin
        m_disp_val = m_cap_val; m_disp_dp = m_cap_dp; m_disp_lz = m_cap_lz;
      end
      if (value_valid) begin
        m_cap_val = value; m_cap_dp = dp_mask; m_cap_lz = lz_en;
      end
      m_n++;
    end
  end

  task automatic strobe(input logic [31:0] v, input logic [7:0] m, input logic lz);
    value = v; dp_mask = m; lz_en = lz; value_valid = 1'b1;
    @(negedge CLK100MHZ);
    value_valid = 1'b0;
  endtask

  task automatic wait_fd();
    int i;
    for (i = 0; i < 4*FRAME; i++) begin
      @(negedge CLK100MHZ);
      if (frame_done) break;
    end
    n_vec++;
    if (i == 4*FRAME) begin
      n_err++;
      $display("FAIL wait_frame_done: frame_done never seen, want a pulse within %0d cycles", 4*FRAME);
    end
  endtask

  // Starts on a frame_done cycle; records the last lit cathode/dp of each digit.
  task automatic capture_frame(output logic [7:0][6:0] cath, output logic [7:0] dpv);
    cath = {8{7'h2A}};
    dpv  = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge CLK100MHZ);
      for (int k = 0; k < 8; k++)
        if (anode == ~(8'h01 << k)) begin
          cath[k] = cathode;
          dpv[k]  = dp;
        end
    end
  endtask

  task automatic test_reset();
    int first;
    CPU_RESET = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK100MHZ);
      n_vec++;
      if ({anode, cathode, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold c%0d: got %h %b %b %b, want ff 1111111 1 0", c, anode, cathode, dp, frame_done);
      end
    end
    CPU_RESET = 1'b0;
    first = -1;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      @(negedge CLK100MHZ);
      if (anode !== 8'hFF) first = c;
    end
    n_vec++;
    if (first != 3) begin
      n_err++;
      $display("FAIL reset_first_lit: got cycle %0d, want 3", first);
    end
    n_vec++;
    if (anode !== 8'hFE) begin
      n_err++;
      $display("FAIL reset_first_digit: got anode %h, want fe", anode);
    end
  endtask

  task automatic test_basic();
    logic [7:0][6:0] cath;
    logic [7:0]      dpv;
    logic [6:0]      exp;
    wait_fd();
    strobe(32'h0000_0034, 8'h00, 1'b0);
    wait_fd();
    capture_frame(cath, dpv);
    for (int k = 0; k < 8; k++) begin
      exp = (k == 0) ? 7'b0011001 : (k == 1) ? 7'b0110000 : 7'b1000000;
      n_vec++;
      if (cath[k] !== exp) begin
        n_err++;
        $display("FAIL basic_digit%0d: got %b, want %b", k, cath[k], exp);
      end
    end
    n_vec++;
    if (dpv !== 8'hFF) begin
      n_err++;
      $display("FAIL basic_dp: got %b, want 11111111", dpv);
    end
  endtask

  task automatic test_lz();
    logic [7:0][6:0] cath;
    logic [7:0]      dpv;
    logic [6:0]      exp;
    wait_fd();
    strobe(32'h0000_0034, 8'h00, 1'b1);
    wait_fd();
    capture_frame(cath, dpv);
    for (int k = 0; k < 8; k++) begin
      exp = (k == 0) ? 7'b0011001 : (k == 1) ? 7'b0110000 : 7'h7F;
      n_vec++;
      if (cath[k] !== exp) begin
        n_err++;
        $display("FAIL lz34_digit%0d: got %b, want %b", k, cath[k], exp);
      end
    end
    strobe(32'h0, 8'hFF, 1'b1);
    wait_fd();
    capture_frame(cath, dpv);
    for (int k = 0; k < 8; k++) begin
      exp = (k == 0) ? 7'b1000000 : 7'h7F;
      n_vec++;
      if (cath[k] !== exp) begin
        n_err++;
        $display("FAIL lz0_digit%0d: got %b, want %b", k, cath[k], exp);
      end
    end
    n_vec++;
    if (dpv !== 8'hFE) begin
      n_err++;
      $display("FAIL lz0_dp: got %b, want 11111110", dpv);
    end
  endtask

  // Entered on a frame_done cycle with value 0 / lz on / all dp requested on display.
  task automatic test_tearing();
    logic [7:0][6:0] cath;
    logic [7:0]      dpv;
    logic [31:0]     nv;
    int              i;
    for (i = 0; i < FRAME && anode !== 8'hF7; i++) @(negedge CLK100MHZ);
    n_vec++;
    if (anode !== 8'hF7) begin
      n_err++;
      $display("FAIL tear_find_digit3: got anode %h, want f7", anode);
    end
    strobe(32'hDEAD_BEEF, 8'h00, 1'b0);
    strobe(32'h1234_5678, 8'h00, 1'b0);
    for (i = 0; i < FRAME && !frame_done; i++) begin
      if (anode !== 8'hFF) begin
        n_vec++;
        if ({cathode, dp} !== {7'h7F, 1'b1}) begin
          n_err++;
          $display("FAIL tear_current_frame anode %h: got %b %b, want 1111111 1", anode, cathode, dp);
        end
      end
      @(negedge CLK100MHZ);
    end
    capture_frame(cath, dpv);
    nv = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (cath[k] !== ref_seg[nv[4*k +: 4]]) begin
        n_err++;
        $display("FAIL tear_next_digit%0d: got %b, want %b", k, cath[k], ref_seg[nv[4*k +: 4]]);
      end
    end
    n_vec++;
    if (cath[7] !== 7'b1111001 || cath[0] !== 7'b0000000) begin
      n_err++;
      $display("FAIL tear_ends: got d7=%b d0=%b, want 1111001 0000000", cath[7], cath[0]);
    end
  endtask

  // Entered on a frame_done cycle showing 0x12345678; strobes into the next boundary cycle.
  task automatic test_boundary();
    logic [7:0][6:0] fa, fb;
    logic [7:0]      dpa, dpb;
    logic [7:0]      prev;
    logic [31:0]     ov, nv;
    int              viol, gap, fd_bad;
    bit              seen_lit;
    ov = 32'h1234_5678; nv = 32'hA5A5_0F0F;
    fa = {8{7'h2A}}; fb = {8{7'h2A}}; dpa = '0; dpb = '0;
    prev = anode; viol = 0; gap = 0; fd_bad = 0; seen_lit = 1'b1;
    for (int c = 1; c <= 3*FRAME; c++) begin
      @(negedge CLK100MHZ);
      if (c == FRAME) value_valid = 1'b0;
      if (frame_done !== ((c % FRAME) == 0)) fd_bad++;
      if (anode !== 8'hFF) begin
        if ($countones(~anode) != 1) viol++;
        if (prev !== 8'hFF && prev !== anode) viol++;
        if (prev === 8'hFF && seen_lit && gap < BC) viol++;
        seen_lit = 1'b1; gap = 0;
        for (int k = 0; k < 8; k++)
          if (anode == ~(8'h01 << k)) begin
            if (c > FRAME && c <= 2*FRAME) begin fa[k] = cathode; dpa[k] = dp; end
            if (c > 2*FRAME)                begin fb[k] = cathode; dpb[k] = dp; end
          end
      end else begin
        gap++;
      end
      prev = anode;
      if (c == FRAME - 1) begin
        value = nv; dp_mask = 8'h0F; lz_en = 1'b0; value_valid = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (fa[k] !== ref_seg[ov[4*k +: 4]]) begin
        n_err++;
        $display("FAIL bnd_old_digit%0d: got %b, want %b", k, fa[k], ref_seg[ov[4*k +: 4]]);
      end
      n_vec++;
      if (fb[k] !== ref_seg[nv[4*k +: 4]]) begin
        n_err++;
        $display("FAIL bnd_new_digit%0d: got %b, want %b", k, fb[k], ref_seg[nv[4*k +: 4]]);
      end
    end
    n_vec++;
    if ({dpa, dpb} !== {8'hFF, 8'hF0}) begin
      n_err++;
      $display("FAIL bnd_dp: got old %b new %b, want 11111111 11110000", dpa, dpb);
    end
    n_vec++;
    if (viol != 0 || fd_bad != 0) begin
      n_err++;
      $display("FAIL bnd_anode_gap: got %0d overlap/gap and %0d frame_done errors, want 0 0", viol, fd_bad);
    end
  endtask

  task automatic test_midreset();
    logic [7:0][6:0] cath;
    logic [7:0]      dpv;
    int              i;
    for (i = 0; i < 2*FRAME && anode !== 8'hDF; i++) @(negedge CLK100MHZ);
    n_vec++;
    if (anode !== 8'hDF) begin
      n_err++;
      $display("FAIL mrst_find_digit5: got anode %h, want df", anode);
    end
    CPU_RESET = 1'b1;
    #1;
    n_vec++;
    if ({anode, cathode, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mrst_async: got %h %b %b %b, want ff 1111111 1 0", anode, cathode, dp, frame_done);
    end
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESET = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK100MHZ);
      n_vec++;
      if (anode !== ((c == 3) ? 8'hFE : 8'hFF)) begin
        n_err++;
        $display("FAIL mrst_restart c%0d: got anode %h, want %h", c, anode, (c == 3) ? 8'hFE : 8'hFF);
      end
    end
    wait_fd();
    capture_frame(cath, dpv);
    n_vec++;
    if (cath !== {8{7'b1000000}} || dpv !== 8'hFF) begin
      n_err++;
      $display("FAIL mrst_cleared: got %h dp %b, want all 1000000 dp 11111111", cath, dpv);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK100MHZ);
      n_vec++;
      if ({anode, cathode, dp, frame_done} !== {e_anode, e_cathode, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL random c%0d: got %h %b %b %b, want %h %b %b %b", c,
                 anode, cathode, dp, frame_done, e_anode, e_cathode, e_dp, e_fd);
      end
      if ($urandom_range(0, 23) == 0) begin
        value       = $urandom >> $urandom_range(0, 31);
        dp_mask     = 8'($urandom);
        lz_en       = 1'($urandom);
        value_valid = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
    end
    value_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_tearing();
    test_boundary();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
